// File: rtl/mem_pckg.sv
// rtl/mem_pckg.sv - shared state encoding and default parameters for the stream read engine
package mem_pckg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int DEF_RD_LAT     = 3;
    localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
    parameter  int WDT   = 8,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WDT-1:0]   din,
    input  logic             pop,
    output logic [WDT-1:0]   dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WDT-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a word when one leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_rd.sv
// rtl/mem_stream_rd.sv - burst reader turning fixed-latency memory reads into a word stream
module mem_stream_rd
    import mem_pckg::*;
#(
    parameter int DATA_WDT   = 64,
    parameter int ADDR_WDT   = 12,
    parameter int LEN_WDT    = 13,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_WDT-1:0] cmd_addr,
    input  logic [LEN_WDT-1:0]  cmd_len,
    output logic                mem_rd_en,
    output logic [ADDR_WDT-1:0] mem_rd_addr,
    input  logic [DATA_WDT-1:0] mem_rd_data,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [DATA_WDT-1:0] dout_data,
    output logic                dout_last,
    output logic                busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_e           state;
    rd_state_e           state_nxt;
    logic [ADDR_WDT-1:0] addr_q;
    logic [LEN_WDT-1:0]  remain_q;
    logic [CNT_W-1:0]    inflight_q;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      occupancy;
    logic [RD_LAT-1:0]   vld_sr;
    logic [RD_LAT-1:0]   last_sr;
    logic                out_en_q;
    logic                accept;
    logic                start;
    logic                issue;
    logic                ret;
    logic                credit_ok;
    logic                last_issue;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_WDT:0]   fifo_dout;

    // Every word already issued or buffered holds a FIFO slot, so the FIFO cannot overflow.
    assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok  = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
    assign accept     = cmd_valid && cmd_ready;
    assign start      = accept && (cmd_len != '0);
    assign last_issue = (remain_q == LEN_WDT'(1));
    assign ret        = vld_sr[RD_LAT-1];

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issue = credit_ok;
                if (issue && last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && fifo_empty) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_en_q   <= 1'b0;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= '0;
            vld_sr     <= '0;
            last_sr    <= '0;
        end else begin
            state    <= state_nxt;
            out_en_q <= 1'b1;
            if (state == IDLE && start) begin
                addr_q   <= cmd_addr;
                remain_q <= cmd_len;
            end else if (issue) begin
                addr_q   <= addr_q + ADDR_WDT'(1);
                remain_q <= remain_q - LEN_WDT'(1);
            end
            case ({issue, ret})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
            vld_sr[0]  <= issue;
            last_sr[0] <= issue && last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    sync_fifo #(
        .WDT   (DATA_WDT + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ret),
        .din   ({last_sr[RD_LAT-1], mem_rd_data}),
        .pop   (dout_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_ready   = out_en_q && (state == IDLE);
    assign busy        = (state != IDLE);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = addr_q;
    assign dout_valid  = !fifo_empty;
    assign dout_data   = fifo_dout[DATA_WDT-1:0];
    // The storage array is not reset, so the tag is masked until a word is really present.
    assign dout_last   = fifo_dout[DATA_WDT] && !fifo_empty;

`ifndef SYNTHESIS
    if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_chk
        $error("mem_stream_rd: FIFO_DEPTH must be at least RD_LAT+1");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_pow2_chk
        $error("mem_stream_rd: FIFO_DEPTH must be a power of 2");
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(ret && fifo_full))
        else $error("mem_stream_rd: return pushed into a full FIFO");
`endif

endmodule

// File: tb/tb_mem_stream_rd.sv
// tb/tb_mem_stream_rd.sv - scoreboard bench for mem_stream_rd at RD_LAT 3, 1 and 8
module tb_mem_stream_rd;

    int   checks = 0;
    int   errors = 0;
    logic clk = 1'b0;
    bit   done [3];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [11:0] a);
        logic [31:0] h;
        h = {20'h0, a} * 32'h9E3779B1;
        return {h, 20'hC0DE0, a};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gb
        localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 8);
        localparam int DEP = (g == 2) ? 16 : 8;

        logic        rst_n;
        logic        cmd_valid;
        logic        cmd_ready;
        logic [11:0] cmd_addr;
        logic [12:0] cmd_len;
        logic        mem_rd_en;
        logic [11:0] mem_rd_addr;
        logic [63:0] mem_rd_data;
        logic        dout_valid;
        logic        dout_ready = 1'b0;
        logic [63:0] dout_data;
        logic        dout_last;
        logic        busy;

        logic [64:0] exp_q [$];
        logic [11:0] addr_q [$];
        int          n_issued = 0;
        int          n_popped = 0;
        int          rdy_mode = 0;
        logic [63:0] pipe [8];
        logic        hold_v = 1'b0;
        logic [64:0] hold_w;

        mem_stream_rd #(
            .RD_LAT     (LAT),
            .FIFO_DEPTH (DEP)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .cmd_valid   (cmd_valid),
            .cmd_ready   (cmd_ready),
            .cmd_addr    (cmd_addr),
            .cmd_len     (cmd_len),
            .mem_rd_en   (mem_rd_en),
            .mem_rd_addr (mem_rd_addr),
            .mem_rd_data (mem_rd_data),
            .dout_valid  (dout_valid),
            .dout_ready  (dout_ready),
            .dout_data   (dout_data),
            .dout_last   (dout_last),
            .busy        (busy)
        );

        function automatic string tag(input string s);
            return $sformatf("lat%0d_%s", LAT, s);
        endfunction

        // Memory primitive: data for a sampled read appears LAT cycles later, garbage otherwise.
        assign mem_rd_data = pipe[LAT-1];
        always @(posedge clk) begin
            pipe[0] <= mem_rd_en ? data_of(mem_rd_addr) : {$urandom, $urandom};
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end

        always @(posedge clk) begin
            #1;
            case (rdy_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (mem_rd_en) begin
                    chk(tag("rd_expected"), addr_q.size() != 0, 1);
                    if (addr_q.size() != 0) chk(tag("rd_addr"), mem_rd_addr, addr_q.pop_front());
                    chk(tag("no_overflow"), (n_issued + 1 - n_popped) <= DEP, 1);
                    n_issued++;
                end
                if (hold_v) begin
                    chk(tag("hold_valid"), dout_valid, 1);
                    chk(tag("hold_word"), {dout_last, dout_data}, hold_w);
                end
                if (dout_valid && dout_ready) begin
                    chk(tag("word_expected"), exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk(tag("word"), {dout_last, dout_data}, exp_q.pop_front());
                    n_popped++;
                end
                hold_v = dout_valid && !dout_ready;
                hold_w = {dout_last, dout_data};
            end
        end

        task automatic send(input logic [11:0] a, input logic [12:0] l);
            int n;
            for (int i = 0; i < int'(l); i++) begin
                logic [11:0] ad;
                ad = a + 12'(i);
                addr_q.push_back(ad);
                exp_q.push_back({i == int'(l) - 1, data_of(ad)});
            end
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            cmd_addr  = a;
            cmd_len   = l;
            n = 0;
            while (!cmd_ready && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            chk(tag("cmd_accept_in_time"), n < 2000, 1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        endtask

        task automatic wait_idle(input string nm);
            int n;
            n = 0;
            while ((exp_q.size() != 0 || busy) && n < 20000) begin
                @(posedge clk); #1;
                n++;
            end
            chk(tag(nm), n < 20000, 1);
        endtask

        task automatic chk_reset_outs(input string nm);
            chk(tag({nm, "_cmd_ready"}), cmd_ready, 0);
            chk(tag({nm, "_rd_en"}), mem_rd_en, 0);
            chk(tag({nm, "_rd_addr"}), mem_rd_addr, 0);
            chk(tag({nm, "_dout_valid"}), dout_valid, 0);
            chk(tag({nm, "_dout_last"}), dout_last, 0);
            chk(tag({nm, "_busy"}), busy, 0);
        endtask

        task automatic bring_up();
            rst_n     = 1'b0;
            cmd_valid = 1'b0;
            cmd_addr  = '0;
            cmd_len   = '0;
            #12;
            chk_reset_outs("reset");
            @(posedge clk); #1;
            rst_n = 1'b1;
            chk(tag("ready_before_edge"), cmd_ready, 0);
            @(posedge clk); #1;
            chk(tag("ready_after_reset"), cmd_ready, 1);
        endtask

        task automatic run_random();
            int words;
            int base;
            words = 0;
            base  = n_popped;
            rdy_mode = 1;
            while (words < 1000) begin
                logic [12:0] l;
                l = 13'($urandom_range(0, 40));
                send(12'($urandom), l);
                words += int'(l);
            end
            wait_idle("random_drain");
            chk(tag("random_all_delivered"), n_popped - base, words);
            chk(tag("random_no_leftover_rd"), addr_q.size(), 0);
        endtask

        if (g == 0) begin : g_directed
            initial begin
                int n;
                int base;
                bring_up();

                rdy_mode = 0;
                send(12'h010, 13'd4);
                n = 0;
                while (!dout_valid && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk(tag("first_latency"), n, LAT + 1);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    chk(tag("back_to_back_valid"), dout_valid, 1);
                end
                wait_idle("burst4_drain");

                send(12'hFFE, 13'd4);
                wait_idle("wrap_drain");

                send(12'h123, 13'd0);
                for (int k = 0; k < 5; k++) begin
                    chk(tag("len0_ready"), cmd_ready, 1);
                    chk(tag("len0_busy"), busy, 0);
                    chk(tag("len0_rd_en"), mem_rd_en, 0);
                    @(posedge clk); #1;
                end

                rdy_mode = 2;
                base = n_issued;
                send(12'h100, 13'd20);
                repeat (12) @(posedge clk);
                #1;
                chk(tag("stall_issue_at_credit"), n_issued - base, DEP);
                chk(tag("stall_valid"), dout_valid, 1);
                base = n_popped;
                rdy_mode = 0;
                wait_idle("stall_drain");
                chk(tag("stall_all_delivered"), n_popped - base, 20);

                base = n_popped;
                send(12'h200, 13'd16);
                n = 0;
                while (n_popped - base < 3 && n < 200) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk(tag("reach_word3"), n < 200, 1);
                #2;
                rst_n = 1'b0;
                #1;
                chk_reset_outs("midburst");
                exp_q.delete();
                addr_q.delete();
                n_issued = 0;
                n_popped = 0;
                @(posedge clk); #1;
                chk_reset_outs("held");
                rst_n = 1'b1;
                chk(tag("ready_before_edge2"), cmd_ready, 0);
                @(posedge clk); #1;
                chk(tag("ready_after_reset2"), cmd_ready, 1);
                send(12'h5A0, 13'd2);
                repeat (LAT + 4) @(posedge clk);
                #1;
                wait_idle("post_reset_drain");
                chk(tag("post_reset_words"), n_popped, 2);

                run_random();
                done[g] = 1'b1;
            end
        end else begin : g_random
            initial begin
                bring_up();
                run_random();
                done[g] = 1'b1;
            end
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(done[0] && done[1] && done[2]) && n < 90000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (!(done[0] && done[1] && done[2])) begin
            errors++;
            $display("FAIL global_timeout: done %0d%0d%0d expected 111", done[0], done[1], done[2]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stream_rd.md
MEM_STREAM_RD -- requirements
Module: mem_stream_rd

Interface
REQ-001 The module SHALL have parameter DATA_WDT, default 64, which sets the memory word and stream data width.
REQ-002 The module SHALL have parameter ADDR_WDT, default 12, which sets the memory read address width.
REQ-003 The module SHALL have parameter LEN_WDT, default 13, which sets the command burst length width in words.
REQ-004 The module SHALL have parameter RD_LAT, default 3, which is the number of cycles from a sampled mem_rd_en to valid mem_rd_data (range 1 to 8).
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 8, which is the return buffer depth; it SHALL be a power of 2 and at least RD_LAT+1.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The module SHALL have port cmd_valid, input, 1 bit: a burst command is offered.
REQ-009 The module SHALL have port cmd_ready, output, 1 bit: a command is accepted; high only in IDLE.
REQ-010 The module SHALL have port cmd_addr, input, ADDR_WDT bits: the burst start address.
REQ-011 The module SHALL have port cmd_len, input, LEN_WDT bits: the number of words to read; 0 means no read.
REQ-012 The module SHALL have port mem_rd_en, output, 1 bit: read strobe to the memory primitive.
REQ-013 The module SHALL have port mem_rd_addr, output, ADDR_WDT bits: the read address.
REQ-014 The module SHALL have port mem_rd_data, input, DATA_WDT bits: the memory read data.
REQ-015 The module SHALL have port dout_valid, output, 1 bit: a stream word is available.
REQ-016 The module SHALL have port dout_ready, input, 1 bit: the consumer accepts the word.
REQ-017 The module SHALL have port dout_data, output, DATA_WDT bits: the stream word.
REQ-018 The module SHALL have port dout_last, output, 1 bit: marks the final word of the burst.
REQ-019 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE and DRAIN.
REQ-021 In IDLE, a cmd_valid&cmd_ready handshake with cmd_len>0 SHALL capture the address and length and move the FSM to ISSUE; with cmd_len=0 the command SHALL be consumed and the FSM SHALL stay in IDLE.
REQ-022 In ISSUE, mem_rd_en SHALL be asserted in a cycle only if inflight+fifo_count < FIFO_DEPTH (credit rule), so the FIFO never overflows.
REQ-023 Each issued read SHALL increment mem_rd_addr by 1, with modulo-2^ADDR_WDT wrap-around and no error.
REQ-024 The FSM SHALL move from ISSUE to DRAIN in the cycle after the final read issues.
REQ-025 The FSM SHALL move from DRAIN to IDLE once inflight=0, the FIFO is empty and the last word has been handshaked.
REQ-026 An RD_LAT-deep valid shift register SHALL track issued reads; when its tap is set, mem_rd_data SHALL be pushed into the FIFO in that cycle.
REQ-027 The inflight counter SHALL increment on issue and decrement on return; a simultaneous issue and return SHALL leave it unchanged.
REQ-028 dout_valid SHALL equal FIFO not-empty, and a word SHALL leave the FIFO on dout_valid&dout_ready.
REQ-029 dout_data and dout_last SHALL be held stable while dout_valid is high and dout_ready is low.
REQ-030 dout_last SHALL be high exactly on the cmd_len-th word, tracked with a per-word last tag stored in the FIFO.
REQ-031 A simultaneous FIFO push and pop SHALL be legal, including a push and pop on an empty FIFO.
REQ-032 With dout_ready held high and no stall, sustained throughput SHALL be one word per cycle, and first-word latency SHALL be RD_LAT+1 cycles from command acceptance.
REQ-033 A cmd_valid received while busy SHALL be ignored (cmd_ready=0).

Reset
REQ-034 Asserting rst_n low SHALL asynchronously clear the FSM to IDLE, all counters to 0, the valid shift register to 0 and the FIFO pointers to 0.
REQ-035 During reset, the outputs SHALL be: cmd_ready=0, mem_rd_en=0, mem_rd_addr=0, dout_valid=0, dout_last=0, busy=0.
REQ-036 Reset asserted mid-burst SHALL abort the burst, and reads still in flight SHALL be discarded.
REQ-037 cmd_ready SHALL rise in the first cycle after rst_n deasserts.

Structure
REQ-038 The FSM state enum and the default RD_LAT/FIFO_DEPTH constants SHALL live in mem_pckg.
REQ-039 The return buffer SHALL be a separate sub-module, sync_fifo: parameterised width and depth, async active-low reset, with push, pop, full, empty and count.
REQ-040 The module SHALL include translate_off assertions checking FIFO_DEPTH>=RD_LAT+1 and that no push occurs when full.

Verification
REQ-041 The bench SHALL cover: cmd_addr=0x010, cmd_len=4, dout_ready=1 -> words at 0x010..0x013 in order, first dout_valid RD_LAT+1 cycles after acceptance, dout_last only on the 4th.
REQ-042 The bench SHALL cover: cmd_len=20 with dout_ready low for 10 cycles -> FIFO fills, mem_rd_en stops at credit, no word lost or duplicated, all 20 delivered.
REQ-043 The bench SHALL cover: cmd_addr=0xFFE, cmd_len=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-044 The bench SHALL cover: cmd_len=0 -> cmd_ready stays high, busy stays 0, no mem_rd_en.
REQ-045 The bench SHALL cover: rst_n pulsed low at word 3 of a 16-word burst -> outputs go to reset values immediately, and the next 2-word command returns clean data with no stale words.
REQ-046 The bench SHALL cover: random dout_ready at 50% over 1000 words with RD_LAT=1 and with RD_LAT=8 -> data matches the memory model and there is no FIFO overflow.
